fractal_colorizer: RTL and testbench

FRACTAL_COLORIZER -- requirements
Module: fractal_colorizer

---
 rtl/fractal_colorizer.sv | 111 +++++++++++
 tb/tb_fractal_colorizer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_colorizer.sv
// Maps fractal iteration counts to RGB through a writable 256-entry palette and
// streams the colours out over AXI4-Stream, resyncing to frame starts after loss.
module fractal_colorizer #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_frame_start,
  input  logic        s_line_end,
  input  logic        s_valid,
  input  logic        pal_we,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_wdata,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        overflow,
  input  logic        overflow_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SYNC, RUN, DROP} state_t;
  typedef struct packed {
    logic        user;
    logic        last;
    logic [23:0] color;
  } beat_t;

  state_t        state;
  logic [23:0]   pal_mem [256];
  beat_t         fifo_mem [FIFO_DEPTH];
  beat_t         s1_beat, head;
  logic          s1_vld;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] occ;
  logic          acceptable, accept, ovf_set, push, pop;

  // Entries are stored XOR-ed with the grey ramp, so a zero-initialised RAM
  // reads back {i,i,i} at power-up and reset never has to touch it.
  always_ff @(posedge clk)
    if (pal_we) pal_mem[pal_addr] <= pal_wdata ^ {3{pal_addr}};

  // Stage 1: lookup; the read sees the pre-write value on a same-cycle write.
  always_ff @(posedge clk)
    s1_beat <= '{user: s_frame_start, last: s_line_end,
                 color: pal_mem[s_data] ^ {3{s_data}}};

  // Beats still in the lookup register count against FIFO space.
  assign occ        = {1'b0, count} + {{(AW+1){1'b0}}, s1_vld};
  assign acceptable = occ < (AW+2)'(FIFO_DEPTH);

  always_comb begin
    accept  = 1'b0;
    ovf_set = 1'b0;
    case (state)
      RUN: begin
        accept  = s_valid && acceptable;
        ovf_set = s_valid && !acceptable;
      end
      default: accept = s_valid && s_frame_start && acceptable;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= SYNC;
      overflow <= 1'b0;
    end else begin
      case (state)
        RUN:     if (ovf_set) state <= DROP;
        default: if (accept)  state <= RUN;
      endcase
      if (ovf_set)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end

  // Stage 2: the looked-up beat is written into the FIFO.
  assign push = s1_vld;
  assign pop  = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= s1_beat;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_vld <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      s1_vld <= accept;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end

  // First-word-fall-through head; outputs forced to zero when empty.
  assign head          = fifo_mem[rd_ptr];
  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head.color : 24'h0;
  assign m_axis_tuser  = m_axis_tvalid && head.user;
  assign m_axis_tlast  = m_axis_tvalid && head.last;
endmodule

// File: tb/tb_fractal_colorizer.sv
// Directed bench for fractal_colorizer: frame sync, palette timing, overflow,
// stall stability and asynchronous reset flush.
module tb_fractal_colorizer;
  logic        clk, reset;
  logic [7:0]  s_data;
  logic        s_frame_start, s_line_end, s_valid;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser, m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic        overflow, overflow_clr;

  fractal_colorizer #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_frame_start(s_frame_start),
    .s_line_end(s_line_end), .s_valid(s_valid), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [23:0] c;
    logic        u, l;
    int          cyc;
  } obs_t;

  typedef struct {
    logic [7:0]  d;
    logic        fs, le, out;
    logic [23:0] c;
    logic        u, l;
  } vec_t;

  obs_t out_q[$];
  int   cyc;
  int   n_tests, n_fail;
  int   stab_n, stab_bad;
  logic prev_stall;
  logic [25:0] prev_out;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!reset && m_axis_tvalid && m_axis_tready)
      out_q.push_back('{m_axis_tdata, m_axis_tuser, m_axis_tlast, cyc});

  // Outputs must not move while a beat is presented but not taken.
  always @(negedge clk) begin
    if (prev_stall && m_axis_tvalid) begin
      stab_n = stab_n + 1;
      if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} != prev_out) stab_bad = stab_bad + 1;
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_out   = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
  end

  function automatic logic [23:0] grey(input logic [7:0] d);
    return {d, d, d};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_beat(input string nm, input int idx, input logic [23:0] c,
                            input logic u, input logic l);
    check({nm, "_present"}, (out_q.size() > idx) ? 32'd1 : 32'd0, 32'd1);
    if (out_q.size() > idx)
      check(nm, {6'd0, out_q[idx].c, out_q[idx].u, out_q[idx].l}, {6'd0, c, u, l});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic fs, input logic le);
    s_valid = 1'b1; s_data = d; s_frame_start = fs; s_line_end = le;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_frame_start = 1'b0; s_line_end = 1'b0;
  endtask

  vec_t vecs[10];
  int   base, in_cyc, k;

  initial begin
    vecs[0] = '{8'h01, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 1'b0, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0};
    vecs[2] = '{8'h10, 1'b1, 1'b0, 1'b1, 24'h101010, 1'b1, 1'b0};
    vecs[3] = '{8'h11, 1'b0, 1'b0, 1'b1, 24'h111111, 1'b0, 1'b0};
    vecs[4] = '{8'h12, 1'b0, 1'b0, 1'b1, 24'h121212, 1'b0, 1'b0};
    vecs[5] = '{8'h13, 1'b0, 1'b1, 1'b1, 24'h131313, 1'b0, 1'b1};
    vecs[6] = '{8'h14, 1'b0, 1'b0, 1'b1, 24'h141414, 1'b0, 1'b0};
    vecs[7] = '{8'h15, 1'b0, 1'b0, 1'b1, 24'h151515, 1'b0, 1'b0};
    vecs[8] = '{8'h16, 1'b0, 1'b0, 1'b1, 24'h161616, 1'b0, 1'b0};
    vecs[9] = '{8'h17, 1'b0, 1'b1, 1'b1, 24'h171717, 1'b0, 1'b1};

    n_tests = 0; n_fail = 0;
    reset = 1'b1; s_valid = 1'b0; s_data = 8'h0; s_frame_start = 1'b0; s_line_end = 1'b0;
    pal_we = 1'b0; pal_addr = 8'h0; pal_wdata = 24'h0; m_axis_tready = 1'b1; overflow_clr = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("rst_tdata", {8'd0, m_axis_tdata}, 32'd0);
    check("rst_tuser_tlast", {30'd0, m_axis_tuser, m_axis_tlast}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;
    idle(2);

    // 4x2 grey frame, joined mid-frame
    base = out_q.size();
    in_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) in_cyc = cyc;
      send(vecs[i].d, vecs[i].fs, vecs[i].le);
    end
    idle(6);
    k = 0;
    for (int i = 0; i < 10; i++)
      if (vecs[i].out) begin
        check_beat("frame_beat", base + k, vecs[i].c, vecs[i].u, vecs[i].l);
        k++;
      end
    check("frame_count", out_q.size() - base, 32'd8);
    if (out_q.size() > base) check("first_latency", out_q[base].cyc - in_cyc, 32'd2);

    // Palette write vs same-cycle / next-cycle lookup
    base = out_q.size();
    pal_we = 1'b1; pal_addr = 8'd5; pal_wdata = 24'hFF0000;
    send(8'd5, 1'b0, 1'b0);
    pal_we = 1'b0;
    send(8'd5, 1'b0, 1'b0);
    idle(4);
    check_beat("pal_same_cycle", base, 24'h050505, 1'b0, 1'b0);
    check_beat("pal_next_cycle", base + 1, 24'hFF0000, 1'b0, 1'b0);

    // Overflow with tready low; clear coinciding with the loss
    base = out_q.size();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 8'(100 + i); s_frame_start = (i == 0); s_line_end = 1'b0;
      overflow_clr = (i == 16);
      @(negedge clk);
      if (i == 16) check("ovf_before_loss", {31'd0, overflow}, 32'd0);
      if (i == 17) check("ovf_set_with_clr", {31'd0, overflow}, 32'd1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0; s_frame_start = 1'b0; overflow_clr = 1'b0;
    idle(2);
    check("stalled_no_out", out_q.size() - base, 32'd0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(200 + i), 1'b0, 1'b0);
    idle(24);
    check("drain_count", out_q.size() - base, 32'd16);
    for (int i = 0; i < 16; i++)
      check_beat("drain_beat", base + i, grey(8'(100 + i)), i == 0, 1'b0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    send(8'h30, 1'b1, 1'b0);
    idle(4);
    check("resync_count", out_q.size() - base, 32'd17);
    check_beat("resync_beat", base + 16, 24'h303030, 1'b1, 1'b0);

    // tready toggling, input at half rate
    base = out_q.size();
    for (int i = 0; i < 128; i++) begin
      m_axis_tready = (i % 2) == 1;
      s_valid = (i % 2) == 0;
      s_data = 8'(64 + i / 2);
      s_frame_start = (i == 0);
      s_line_end = ((i / 2) % 8) == 7;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0; s_frame_start = 1'b0; s_line_end = 1'b0;
    m_axis_tready = 1'b1;
    idle(10);
    check("toggle_count", out_q.size() - base, 32'd64);
    for (int j = 0; j < 64; j++)
      check_beat("toggle_beat", base + j, grey(8'(64 + j)), j == 0, (j % 8) == 7);
    check("toggle_no_ovf", {31'd0, overflow}, 32'd0);
    check("stall_seen", (stab_n > 0) ? 32'd1 : 32'd0, 32'd1);
    check("stall_stable", stab_bad, 32'd0);

    // Asynchronous reset with beats buffered
    base = out_q.size();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(8'h40 + i), i == 0, 1'b0);
    idle(3);
    @(negedge clk);
    check("buffered_valid", {31'd0, m_axis_tvalid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check("async_rst_tdata", {8'd0, m_axis_tdata}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    check("post_rst_ovf", {31'd0, overflow}, 32'd0);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 3; i++) send(8'(8'h50 + i), 1'b0, 1'b0);
    idle(5);
    check("post_rst_no_out", out_q.size() - base, 32'd0);
    send(8'h60, 1'b1, 1'b1);
    idle(4);
    check("post_rst_count", out_q.size() - base, 32'd1);
    check_beat("post_rst_beat", base, 24'h606060, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
